// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- clocked EX-stage ALU with iterative multiply/divide into HI/LO.
//
// Single-cycle ops (logic, add/sub, shifts, compares) register their result
// on the edge that samples `start` and pulse `done` right after it. MULT/MULTU
// (and DIV/DIVU when enabled) run a WIDTH-step unsigned shift-add or
// restoring-divide core on operand magnitudes. A final FIX cycle applies the
// sign correction and writes hi/lo. Results appear WIDTH+2 edges after the
// start edge, counting the start edge itself.
//
// Build option:
//   ALU_SEQ_DIV_EN  defined   -> DIVU/DIV implemented (lo = quotient,
//                                hi = remainder).
//                   undefined -> no divider; opcodes 1110/1111 complete in one
//                                cycle with result 0 and leave hi/lo alone.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst_n       synchronous active-low reset
//   start       operation request, ignored while busy
//   ALUCtrl     opcode, sampled with start
//   input1      operand A (rs); input1[SHW-1:0] is the shift amount
//   input2      operand B (rt/imm); value being shifted for shifts
//   busy        multi-cycle operation in flight
//   done        one-cycle pulse when ALU_result (and hi/lo) update
//   ALU_result  registered result, held until the next done
//   zero        registered (ALU_result == 0), updated with done
//   overflow    signed overflow of ADD/SUB, 0 for everything else
//   hi, lo      multiply/divide result registers
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUCtrl,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALU_result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_XOR   = 4'b0011,
        OP_SLL   = 4'b0100,
        OP_SRL   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLTU  = 4'b0111,
        OP_SLT   = 4'b1000,
        OP_SRA   = 4'b1001,
        OP_MULTU = 4'b1010,
        OP_MULT  = 4'b1011,
        OP_NOR   = 4'b1100,
        OP_RSVD  = 4'b1101,
        OP_DIVU  = 4'b1110,
        OP_DIV   = 4'b1111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    op_e    op;
    state_e state, state_d;

    // Iteration core: hi_acc is the partial product / running remainder,
    // lo_acc holds the multiplier / dividend and collects the low product
    // bits / quotient bits as it shifts.
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] hi_acc, lo_acc, b_mag;
    logic             neg_res;

`ifdef ALU_SEQ_DIV_EN
    logic             op_div;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] a_orig;
    logic [WIDTH:0]   div_shift, div_diff;
`endif

    // Single-cycle datapath
    logic [WIDTH-1:0]        sc_result;
    logic                    sc_overflow;
    logic [WIDTH-1:0]        add_res, sub_res;
    logic signed [WIDTH-1:0] sra_res;
    logic [SHW-1:0]          sa;

    // Operand capture for multi-cycle ops
    logic             is_mul, is_div, is_multi, op_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag_in;

    // Per-step and final-correction values
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign op   = op_e'(ALUCtrl);
    assign busy = (state != S_IDLE);
    assign sa   = input1[SHW-1:0];

    // -----------------------------------------------------------------------
    // Single-cycle result
    // -----------------------------------------------------------------------
    assign add_res = input1 + input2;
    assign sub_res = input1 - input2;
    assign sra_res = $signed(input2) >>> sa;

    // NOTE: every variable assigned in an always_comb gets a default first,
    // so no path through the case can leave it holding a value (a latch).
    always_comb begin
        sc_result   = '0;
        sc_overflow = 1'b0;
        case (op)
            OP_AND:  sc_result = input1 & input2;
            OP_OR:   sc_result = input1 | input2;
            OP_XOR:  sc_result = input1 ^ input2;
            OP_NOR:  sc_result = ~(input1 | input2);
            OP_ADD: begin
                sc_result   = add_res;
                sc_overflow = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                              (add_res[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result   = sub_res;
                sc_overflow = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                              (sub_res[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_SLL:  sc_result = input2 << sa;
            OP_SRL:  sc_result = input2 >> sa;
            OP_SRA:  sc_result = sra_res;
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (input1 < input2)};
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            // Reserved opcode, and the divide opcodes when the divider is
            // left out, produce 0.
            default: sc_result = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Multi-cycle decode and operand magnitudes
    // -----------------------------------------------------------------------
    assign is_mul = (op == OP_MULTU) || (op == OP_MULT);
`ifdef ALU_SEQ_DIV_EN
    assign is_div = (op == OP_DIVU) || (op == OP_DIV);
`else
    assign is_div = 1'b0;
`endif
    assign is_multi = is_mul || is_div;

    // Bit 0 of the opcode selects the signed variant of both MULT and DIV.
    assign op_signed = ALUCtrl[0];
    assign a_neg     = op_signed && input1[WIDTH-1];
    assign b_neg     = op_signed && input2[WIDTH-1];
    assign a_mag     = a_neg ? -input1 : input1;
    assign b_mag_in  = b_neg ? -input2 : input2;

    // -----------------------------------------------------------------------
    // One iteration step
    // -----------------------------------------------------------------------
    always_comb begin
        mul_sum = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], lo_acc[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        // Restoring divide: the running remainder stays below the divisor, so
        // the WIDTH+1-bit difference cannot wrap and its MSB is a clean sign.
        div_shift = {hi_acc, lo_acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag};
        if (op_div) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {lo_acc[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {lo_acc[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Sign correction applied in FIX
    // -----------------------------------------------------------------------
    always_comb begin
        prod = {hi_acc, lo_acc};
        if (neg_res) begin
            prod = -prod;
        end
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
`ifdef ALU_SEQ_DIV_EN
        if (op_div) begin
            if (div_zero) begin
                // The unsigned core already yields an all-ones quotient; the
                // override keeps a negative dividend from being re-signed.
                fix_lo = '1;
                fix_hi = a_orig;
            end else begin
                // The quotient flips when operand signs differ; the remainder
                // follows the dividend. MIN / -1 wraps back to MIN naturally.
                fix_lo = neg_res ? -lo_acc : lo_acc;
                fix_hi = neg_rem ? -hi_acc : hi_acc;
            end
        end
`endif
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, and the reset is
    // an ordinary synchronous branch evaluated on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (start && is_multi) state_d = S_ITER;
            S_ITER: if (cnt == SHW'(WIDTH - 1)) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            hi_acc     <= '0;
            lo_acc     <= '0;
            b_mag      <= '0;
            neg_res    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            op_div     <= 1'b0;
            neg_rem    <= 1'b0;
            div_zero   <= 1'b0;
            a_orig     <= '0;
`endif
            done       <= 1'b0;
            ALU_result <= '0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_multi) begin
                            hi_acc   <= '0;
                            lo_acc   <= a_mag;
                            b_mag    <= b_mag_in;
                            cnt      <= '0;
                            neg_res  <= a_neg ^ b_neg;
`ifdef ALU_SEQ_DIV_EN
                            op_div   <= is_div;
                            neg_rem  <= a_neg;
                            div_zero <= (input2 == '0);
                            a_orig   <= input1;
`endif
                        end else begin
                            ALU_result <= sc_result;
                            zero       <= (sc_result == '0);
                            overflow   <= sc_overflow;
                            done       <= 1'b1;
                        end
                    end
                end
                S_ITER: begin
                    hi_acc <= step_hi;
                    lo_acc <= step_lo;
                    cnt    <= cnt + SHW'(1);
                end
                S_FIX: begin
                    hi         <= fix_hi;
                    lo         <= fix_lo;
                    ALU_result <= fix_lo;
                    zero       <= (fix_lo == '0);
                    overflow   <= 1'b0;
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
